mac_acc_pipe: RTL and testbench

Pipelined, parametrised dot-product MAC with an accumulator. Each valid beat multiplies `pr` element pairs, reduces them through a registered adder stage, and accumulates the beat sums over a framed group of beats into one saturating partial sum. The block is the next-generation replacement for the fixed 16-input MAC in the 1D accelerator datapath. It adds configurable width and channel count, valid/first/last framing, a per-beat unsigned-activation mode, and overflow reporting.

---
 rtl/mac_acc_pipe_if.sv | 27 ++
 rtl/mac_acc_pipe.sv | 155 +++++++++++++++
 tb/tb_mac_acc_pipe.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mac_acc_pipe_if.sv
// Beat and result bundle for the pipelined dot-product MAC.
// The producer side uses the master modport; the MAC uses the slave modport.
interface mac_acc_pipe_if #(
    parameter int bw      = 8,
    parameter int pr      = 16,
    parameter int bw_psum = 2*bw+6
);
    logic                 in_valid;
    logic                 in_first;
    logic                 in_last;
    logic                 unsigned_a;
    logic [pr*bw-1:0]     a;
    logic [pr*bw-1:0]     b;
    logic [bw_psum-1:0]   out;
    logic                 out_valid;
    logic                 out_sat;

    modport master (
        output in_valid, in_first, in_last, unsigned_a, a, b,
        input  out, out_valid, out_sat
    );

    modport slave (
        input  in_valid, in_first, in_last, unsigned_a, a, b,
        output out, out_valid, out_sat
    );
endinterface

// File: rtl/mac_acc_pipe.sv
// Three-stage dot-product MAC: per-element products, registered adder tree,
// then a saturating accumulator framed by first/last flags.
module mac_acc_pipe #(
    parameter int bw      = 8,
    parameter int pr      = 16,
    parameter int bw_psum = 2*bw+6
) (
    input  logic         clk,
    input  logic         reset,
    mac_acc_pipe_if.slave bus
);
    localparam int PW = 2*bw+1;

    // Element a is zero- or sign-extended by mode; b is always signed.
    function automatic logic signed [PW-1:0] mul_elem(
        input logic [bw-1:0] ea,
        input logic [bw-1:0] eb,
        input logic          ua
    );
        logic signed [bw:0] xa;
        logic signed [bw:0] xb;
        xa = {(ua ? 1'b0 : ea[bw-1]), ea};
        xb = {eb[bw-1], eb};
        return PW'(xa) * PW'(xb);
    endfunction

    // Returns {clamped, value}: clamps a one-bit-wider sum into bw_psum bits.
    function automatic logic [bw_psum:0] clamp_sum(input logic signed [bw_psum:0] wide);
        logic [bw_psum:0] res;
        if (wide[bw_psum] != wide[bw_psum-1]) begin
            if (wide[bw_psum] == 1'b0) begin
                res = {1'b1, 1'b0, {(bw_psum-1){1'b1}}};
            end else begin
                res = {1'b1, 1'b1, {(bw_psum-1){1'b0}}};
            end
        end else begin
            res = {1'b0, wide[bw_psum-1:0]};
        end
        return res;
    endfunction

    logic signed [PW-1:0]      w_prod [pr];
    logic signed [PW-1:0]      r_prod [pr];
    logic                      r_p_valid;
    logic                      r_p_first;
    logic                      r_p_last;

    logic signed [bw_psum-1:0] w_sum;
    logic signed [bw_psum-1:0] r_s_sum;
    logic                      r_s_valid;
    logic                      r_s_first;
    logic                      r_s_last;

    logic signed [bw_psum-1:0] w_base;
    logic signed [bw_psum:0]   w_wide;
    logic [bw_psum:0]          w_clamp;
    logic                      w_sat_next;
    logic signed [bw_psum-1:0] r_acc;
    logic                      r_sat;
    logic [bw_psum-1:0]        r_out;
    logic                      r_out_valid;
    logic                      r_out_sat;

    // Per-element products for the incoming beat.
    always_comb begin
        for (int k = 0; k < pr; k++) begin
            w_prod[k] = mul_elem(bus.a[bw*k +: bw], bus.b[bw*k +: bw], bus.unsigned_a);
        end
    end

    // Stage P: product registers; data holds across bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < pr; k++) begin
                r_prod[k] <= '0;
            end
            r_p_valid <= 1'b0;
            r_p_first <= 1'b0;
            r_p_last  <= 1'b0;
        end else begin
            r_p_valid <= bus.in_valid;
            r_p_first <= bus.in_valid & bus.in_first;
            r_p_last  <= bus.in_valid & bus.in_last;
            if (bus.in_valid) begin
                for (int k = 0; k < pr; k++) begin
                    r_prod[k] <= w_prod[k];
                end
            end
        end
    end

    // Reduction of the sign-extended products; width rules out overflow.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < pr; k++) begin
            w_sum = w_sum + bw_psum'(r_prod[k]);
        end
    end

    // Stage S: registered beat sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_sum   <= '0;
            r_s_valid <= 1'b0;
            r_s_first <= 1'b0;
            r_s_last  <= 1'b0;
        end else begin
            r_s_valid <= r_p_valid;
            r_s_first <= r_p_first;
            r_s_last  <= r_p_last;
            if (r_p_valid) begin
                r_s_sum <= w_sum;
            end else begin
                r_s_sum <= r_s_sum;
            end
        end
    end

    // Accumulate onto zero at group start, otherwise onto the running total.
    always_comb begin
        if (r_s_first) begin
            w_base = '0;
        end else begin
            w_base = r_acc;
        end
        w_wide     = (bw_psum+1)'(w_base) + (bw_psum+1)'(r_s_sum);
        w_clamp    = clamp_sum(w_wide);
        w_sat_next = (r_s_first ? 1'b0 : r_sat) | w_clamp[bw_psum];
    end

    // Stage A: accumulator, sticky saturation and registered result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_out       <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_s_valid & r_s_last;
            if (r_s_valid) begin
                r_acc <= w_clamp[bw_psum-1:0];
                r_sat <= w_sat_next;
                if (r_s_last) begin
                    r_out     <= w_clamp[bw_psum-1:0];
                    r_out_sat <= w_sat_next;
                end
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sat   = r_out_sat;
endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed bench for mac_acc_pipe with bw=8, pr=16, bw_psum=22.
module tb_mac_acc_pipe;
    localparam int BW = 8;
    localparam int PR = 16;
    localparam int BWP = 22;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    mac_acc_pipe_if #(.bw(BW), .pr(PR), .bw_psum(BWP)) bus_if ();

    mac_acc_pipe #(.bw(BW), .pr(PR), .bw_psum(BWP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ov, input int o, input int s);
        chk({tag, ".valid"}, int'(bus_if.out_valid), ov);
        chk({tag, ".out"}, int'($signed(bus_if.out)), o);
        chk({tag, ".sat"}, int'(bus_if.out_sat), s);
    endtask

    task automatic set_beat(input logic [7:0] av, input logic [7:0] bv,
                            input logic f, input logic l, input logic ua);
        for (int k = 0; k < PR; k++) begin
            bus_if.a[8*k +: 8] = av;
            bus_if.b[8*k +: 8] = bv;
        end
        bus_if.in_valid   = 1'b1;
        bus_if.in_first   = f;
        bus_if.in_last    = l;
        bus_if.unsigned_a = ua;
    endtask

    task automatic beat(input logic [7:0] av, input logic [7:0] bv,
                        input logic f, input logic l, input logic ua);
        set_beat(av, bv, f, l, ua);
        step();
        bus_if.in_valid = 1'b0;
        bus_if.in_first = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    // Called right after the step of a last beat: result appears two edges later.
    task automatic expect_result(input string tag, input int o, input int s);
        step();
        chk({tag, ".early"}, int'(bus_if.out_valid), 0);
        step();
        chk_out(tag, 1, o, s);
        step();
        chk({tag, ".pulse_end"}, int'(bus_if.out_valid), 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus_if.in_valid   = 1'b0;
        bus_if.in_first   = 1'b0;
        bus_if.in_last    = 1'b0;
        bus_if.unsigned_a = 1'b0;
        bus_if.a          = '0;
        bus_if.b          = '0;

        // Reset with a concurrent beat that must be dropped.
        reset = 1'b1;
        set_beat(8'd5, 8'd5, 1'b1, 1'b1, 1'b0);
        step();
        step();
        chk_out("reset", 0, 0, 0);
        reset = 1'b0;
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("reset_drop", int'(bus_if.out_valid), 0);
        end

        // 1: single beat of ones.
        beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
        expect_result("ones", 16, 0);
        chk("ones_hold", int'($signed(bus_if.out)), 16);

        // 2: 0xFF times 1, unsigned then signed.
        beat(8'hFF, 8'h01, 1'b1, 1'b1, 1'b1);
        expect_result("ua1", 4080, 0);
        beat(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
        expect_result("ua0", -16, 0);

        // 3: 8 beats of 262144 saturate; next group of 4 is clean.
        for (int i = 0; i < 8; i++) begin
            beat(8'h80, 8'h80, (i == 0), (i == 7), 1'b0);
        end
        expect_result("sat8", 2097151, 1);
        for (int i = 0; i < 4; i++) begin
            beat(8'h80, 8'h80, (i == 0), (i == 3), 1'b0);
        end
        expect_result("grp4", 1048576, 0);

        // Sticky: a negative beat after the clamp adds to the clamped value.
        for (int i = 0; i < 8; i++) begin
            beat(8'h80, 8'h80, (i == 0), 1'b0, 1'b0);
        end
        beat(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0);
        expect_result("sticky", 1837055, 1);

        // 4: bubbles inside a group.
        for (int i = 0; i < 3; i++) begin
            beat(8'd2, 8'd3, (i == 0), (i == 2), 1'b0);
            if (i < 2) begin
                step();
                chk("bubble", int'(bus_if.out_valid), 0);
                step();
            end
        end
        expect_result("bubbles", 288, 0);

        // 5: reset aborts a group in flight.
        beat(8'd1, 8'd1, 1'b1, 1'b0, 1'b0);
        beat(8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_out("abort_reset", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_quiet", int'(bus_if.out_valid), 0);
        end
        beat(8'd1, 8'd2, 1'b1, 1'b1, 1'b0);
        expect_result("after_abort", 32, 0);

        // 6: back-to-back single-beat groups.
        set_beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
        step();
        beat(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
        step();
        chk_out("b2b_0", 1, 16, 0);
        step();
        chk_out("b2b_1", 1, -16, 0);
        step();
        chk("b2b_end", int'(bus_if.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
